// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle, occupancy state
// and small decode helpers used by the stage and its handshake controller.
package pipe_pkg;

  typedef struct packed {
    logic       RegFile_WE;
    logic       ALUSource;
    logic       SetFlags;
    logic       MemWE;
    logic       WBSelect;
    logic       OpSource;
    logic [1:0] ALUControl;
    logic [1:0] BranchSelect;
    logic [1:0] OpType;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // A bubble must never write the register file, memory or flags downstream.
  function automatic idex_ctrl_t mask_bubble(input idex_ctrl_t c, input logic valid);
    idex_ctrl_t r;
    r = c;
    if (!valid) begin
      r.RegFile_WE = 1'b0;
      r.MemWE      = 1'b0;
      r.SetFlags   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_fsm.sv
// Occupancy FSM and ready/valid decode for the ID/EX stage.
// PIPE_ID_EX_SKID_EN adds the FULL state and a registered-only ready_o.
module pipe_skid_fsm
  import pipe_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       flush_i,
  input  logic       valid_i,
  input  logic       ready_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] occupancy_o,
`ifdef PIPE_ID_EX_SKID_EN
  output logic       load_skid_o,
  output logic       load_main_skid_o,
`endif
  output logic       load_main_in_o
);

  pipe_state_e state_q, state_d;
  logic        in_fire, out_fire;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = BUSY;
`ifdef PIPE_ID_EX_SKID_EN
        BUSY: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (out_fire && !in_fire) state_d = EMPTY;
        end
        FULL: if (out_fire) state_d = BUSY;
`else
        BUSY: if (out_fire && !in_fire) state_d = EMPTY;
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o     = (state_q != EMPTY);
    occupancy_o = state_occupancy(state_q);
`ifdef PIPE_ID_EX_SKID_EN
    ready_o          = (state_q != FULL);
    load_skid_o      = !flush_i && in_fire && (state_q == BUSY) && !out_fire;
    load_main_skid_o = !flush_i && out_fire && (state_q == FULL);
`else
    // Without a skid slot the stage can only refill as it drains.
    ready_o          = !valid_o | ready_i;
`endif
    load_main_in_o = !flush_i && in_fire &&
                     ((state_q == EMPTY) || ((state_q == BUSY) && out_fire));
  end

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID/EX pipeline register with ready/valid handshake; optional skid slot
// enabled by PIPE_ID_EX_SKID_EN. Payload registers live here, control in pipe_skid_fsm.
module pipe_id_ex_skid
  import pipe_pkg::*;
#(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N-1:0]          RD1_S_i,
  input  logic [N-1:0]          RD2_S_i,
  input  logic [N-1:0]          Extend_i,
  input  logic [V-1:0][L-1:0]   RD1_V_i,
  input  logic [V-1:0][L-1:0]   RD2_V_i,
  input  logic [4:0]            A3_i,
  input  idex_ctrl_t            Ctrl_i,
  output logic [N-1:0]          RD1_S_o,
  output logic [N-1:0]          RD2_S_o,
  output logic [N-1:0]          Extend_o,
  output logic [V-1:0][L-1:0]   RD1_V_o,
  output logic [V-1:0][L-1:0]   RD2_V_o,
  output logic [4:0]            A3_o,
  output idex_ctrl_t            Ctrl_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [1:0]            occupancy_o
);

  localparam int CW = $bits(idex_ctrl_t);
  localparam int PW = 3 * N + 2 * V * L + 5 + CW;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_q, main_d;
  logic          load_main_in;
  idex_ctrl_t    ctrl_held;

  assign in_payload = {RD1_S_i, RD2_S_i, Extend_i, RD1_V_i, RD2_V_i, A3_i, Ctrl_i};

`ifdef PIPE_ID_EX_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          load_skid, load_main_skid;
`endif

  pipe_skid_fsm u_fsm (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .flush_i          (flush_i),
    .valid_i          (valid_i),
    .ready_i          (ready_i),
    .ready_o          (ready_o),
    .valid_o          (valid_o),
    .occupancy_o      (occupancy_o),
`ifdef PIPE_ID_EX_SKID_EN
    .load_skid_o      (load_skid),
    .load_main_skid_o (load_main_skid),
`endif
    .load_main_in_o   (load_main_in)
  );

  always_comb begin
    main_d = main_q;
    if (load_main_in) main_d = in_payload;
`ifdef PIPE_ID_EX_SKID_EN
    // Exclusive with load_main_in: one is only raised in FULL, the other never.
    if (load_main_skid) main_d = skid_q;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) main_q <= '0;
    else        main_q <= main_d;
  end

`ifdef PIPE_ID_EX_SKID_EN
  always_comb begin
    skid_d = skid_q;
    if (load_skid) skid_d = in_payload;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) skid_q <= '0;
    else        skid_q <= skid_d;
  end
`endif

  assign {RD1_S_o, RD2_S_o, Extend_o, RD1_V_o, RD2_V_o, A3_o, ctrl_held} = main_q;
  assign Ctrl_o = mask_bubble(ctrl_held, valid_o);

endmodule

// File: doc/pipe_id_ex_skid.md
PIPE_ID_EX_SKID -- requirements
Module: pipe_id_ex_skid

Interface
REQ-001 SHALL have parameter N, default 32, scalar operand width.
REQ-002 SHALL have parameter V, default 20, vector lane count.
REQ-003 SHALL have parameter L, default 8, vector lane width.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous kill of all held entries.
REQ-007 SHALL have port valid_i  input  1  upstream (ID) entry valid.
REQ-008 SHALL have port ready_o  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have ports RD1_S_i, RD2_S_i, Extend_i  input  N  scalar operands, immediate.
REQ-010 SHALL have ports RD1_V_i, RD2_V_i  input  V x L  vector operands.
REQ-011 SHALL have port A3_i  input  5  destination register.
REQ-012 SHALL have port Ctrl_i  input  idex_ctrl_t  packed control bundle.
REQ-013 SHALL have ports RD1_S_o, RD2_S_o, Extend_o, RD1_V_o, RD2_V_o, A3_o, Ctrl_o  output  as inputs  registered payload to EX.
REQ-014 SHALL have port valid_o  output  1  EX-side entry valid.
REQ-015 SHALL have port ready_i  input  1  EX accepts entry.
REQ-016 SHALL have port occupancy_o  output  2  entries held (0..2).

Function
REQ-017 SHALL transfer in on in_fire = valid_i & ready_o, out on out_fire = valid_o & ready_i.
REQ-018 SHALL implement FSM EMPTY / BUSY (main reg) / FULL (main + skid reg).
REQ-019 EMPTY: in_fire -> BUSY, main <= input; else stay.
REQ-020 BUSY: in_fire & out_fire -> BUSY, main <= input; in_fire & !out_fire -> FULL, skid <= input; out_fire only -> EMPTY.
REQ-021 FULL: out_fire -> BUSY, main <= skid; else hold; ready_o = 0 in FULL.
REQ-022 SHALL drive ready_o = (state != FULL), decoded from state register only (no ready_i -> ready_o path).
REQ-023 SHALL drive valid_o = (state != EMPTY); occupancy_o = 0/1/2 for EMPTY/BUSY/FULL.
REQ-024 SHALL hold all output payload stable while valid_o & !ready_i.
REQ-025 SHALL preserve entry order; no entry dropped or duplicated except by flush.
REQ-026 Latency: an entry accepted in EMPTY/BUSY appears on outputs next cycle.
REQ-027 flush_i SHALL force EMPTY next cycle, with priority over simultaneous in_fire/out_fire; input that cycle discarded.
REQ-028 SHALL mask Ctrl_o.RegFile_WE, Ctrl_o.MemWE, Ctrl_o.SetFlags to 0 whenever valid_o = 0 (bubble safe).
REQ-029 SHALL ignore payload inputs when valid_i = 0; data outputs may hold stale values when valid_o = 0.

Reset
REQ-030 On RST_N low, SHALL asynchronously force EMPTY, valid_o = 0, ready_o = 1, occupancy_o = 0, all payload outputs and skid register to 0.
REQ-031 Reset mid-transfer SHALL discard both entries; first accept after RST_N deasserts.

Configuration
REQ-032 Macro PIPE_ID_EX_SKID_EN defined: skid register and FULL state compiled in, as REQ-018..022.
REQ-033 Macro undefined: no skid register, no FULL state; ready_o = !valid_o | ready_i (combinational); occupancy_o max 1; all other requirements unchanged.

Structure
REQ-034 Package pipe_pkg SHALL hold idex_ctrl_t (RegFile_WE, ALUSource, SetFlags, MemWE, WBSelect, OpSource: 1 bit each; ALUControl, BranchSelect, OpType: 2 bits each) and state enum pipe_state_e.
REQ-035 FSM and ready/valid decode SHALL be sub-module pipe_skid_fsm; datapath registers stay in top.

Verification
REQ-036 Reset, then valid_i=1, RD1_S_i=0x1234, ready_i=1 -> valid_o=1, RD1_S_o=0x1234 next cycle, occupancy_o=1.
REQ-037 BUSY, ready_i=0, accept A=0x11 then B=0x22 -> occupancy_o=2, ready_o=0; ready_i=1 -> outputs 0x11 then 0x22 on consecutive cycles.
REQ-038 FULL, flush_i=1 with valid_i=1 -> next cycle valid_o=0, occupancy_o=0, Ctrl_o.MemWE=0, ready_o=1.
REQ-039 Stream 100 entries, random valid_i/ready_i -> output sequence equals input sequence, no loss; ready_o never depends on same-cycle ready_i (macro defined).
REQ-040 RST_N pulsed low mid-cycle while FULL -> valid_o=0 immediately, no clock edge needed; macro undefined run: ready_i=0, valid_o=1 -> ready_o=0.
